// File: rtl/sram_1rw1r_responder_pkg.sv
// Shared sizing for the SRAM responder slice. These mirror the OpenRAM macro
// defines: DATA_SIZE, ADDR_SIZE and WMASK_SIZE.
package sram_1rw1r_responder_pkg;
  localparam int unsigned DATA_SIZE  = 32;
  localparam int unsigned ADDR_SIZE  = 8;
  localparam int unsigned WMASK_SIZE = DATA_SIZE / 8;
  localparam int unsigned DEPTH_DEF  = 256;
  localparam int unsigned BYTE_W     = 8;
endpackage

// File: rtl/sram_wmask_merge.sv
// Byte-lane write-mask merge. Each output byte is the new byte where its mask
// bit is set and the old byte otherwise. Purely combinational.
module sram_wmask_merge
  import sram_1rw1r_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_SIZE,
  parameter int unsigned WMASK_WIDTH = DATA_WIDTH / BYTE_W
) (
  input  logic [DATA_WIDTH-1:0]  old_word,
  input  logic [DATA_WIDTH-1:0]  new_word,
  input  logic [WMASK_WIDTH-1:0] mask,
  output logic [DATA_WIDTH-1:0]  merged
);
  for (genvar i = 0; i < WMASK_WIDTH; i++) begin : g_lane
    assign merged[BYTE_W*i +: BYTE_W] = mask[i] ? new_word[BYTE_W*i +: BYTE_W]
                                                : old_word[BYTE_W*i +: BYTE_W];
  end
endmodule

// File: rtl/sram_1rw1r_responder.sv
// Standard-cell stand-in for an OpenRAM 1rw1r macro: port 0 read/write with a
// byte mask, port 1 read-only, both registered with one edge of latency.
// Out-of-range accesses are dropped (reads return 0) and flagged; a port 0
// write colliding with a port 1 read of the same address is flagged.
// Optional: SRAM_RESPONDER_WRITE_THROUGH_EN makes a colliding port 1 read
// return the merged post-write word instead of the pre-write word.
module sram_1rw1r_responder
  import sram_1rw1r_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_SIZE,
  parameter int unsigned WMASK_WIDTH = DATA_WIDTH / BYTE_W,
  parameter int unsigned ADDR_WIDTH  = ADDR_SIZE,
  parameter int unsigned NUM_WORDS   = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   rw_conflict,
  output logic                   oob_access
);
  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  logic                  a0_ok, a1_ok, rd0, wr0, rd1, hit;
  logic [IDX_W-1:0]      idx0, idx1;
  logic [DATA_WIDTH-1:0] merged;

  assign a0_ok = 32'(addr0) < NUM_WORDS;
  assign a1_ok = 32'(addr1) < NUM_WORDS;
  // Out-of-range addresses are steered to word 0 so the array is never
  // indexed past its end; the ok bits keep those accesses from taking effect.
  assign idx0  = a0_ok ? addr0[IDX_W-1:0] : '0;
  assign idx1  = a1_ok ? addr1[IDX_W-1:0] : '0;
  assign rd0   = !csb0 &&  web0;
  assign wr0   = !csb0 && !web0;
  assign rd1   = !csb1;
  assign hit   = wr0 && rd1 && (addr0 == addr1);

  sram_wmask_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .WMASK_WIDTH(WMASK_WIDTH)
  ) u_merge (
    .old_word(mem[idx0]),
    .new_word(din0),
    .mask    (wmask0),
    .merged  (merged)
  );

  // Array write; contents survive reset, but nothing is written while it is held.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
    end else if (wr0 && a0_ok) begin
      mem[idx0] <= merged;
    end
  end

  // Read registers and one-cycle status pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout0       <= '0;
      dout1       <= '0;
      rw_conflict <= 1'b0;
      oob_access  <= 1'b0;
    end else begin
      if (rd0) dout0 <= a0_ok ? mem[idx0] : '0;
`ifdef SRAM_RESPONDER_WRITE_THROUGH_EN
      if (rd1) dout1 <= !a1_ok ? '0 : (hit ? merged : mem[idx1]);
`else
      // Non-blocking read of the array gives the pre-write word on a collision.
      if (rd1) dout1 <= a1_ok ? mem[idx1] : '0;
`endif
      rw_conflict <= hit;
      oob_access  <= (!csb0 && !a0_ok) || (rd1 && !a1_ok);
    end
  end
endmodule

// File: tb/tb_sram_1rw1r_responder.sv
// Directed bench for sram_1rw1r_responder. Two instances share one stimulus:
// u_dut at full depth (256) and u_oob at depth 200 for out-of-range checks.
module tb_sram_1rw1r_responder;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1;
  logic [3:0]  wmask0 = '0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [31:0] din0 = '0;
  logic [31:0] dout0_a, dout1_a, dout0_b, dout1_b;
  logic        conf_a, oob_a, conf_b, oob_b;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  sram_1rw1r_responder #(.NUM_WORDS(256)) u_dut (
    .clk(clk), .resetn(resetn), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout0_a), .csb1(csb1), .addr1(addr1),
    .dout1(dout1_a), .rw_conflict(conf_a), .oob_access(oob_a));

  sram_1rw1r_responder #(.NUM_WORDS(200)) u_oob (
    .clk(clk), .resetn(resetn), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout0_b), .csb1(csb1), .addr1(addr1),
    .dout1(dout1_b), .rw_conflict(conf_b), .oob_access(oob_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
  endtask

  task automatic rd0(input logic [7:0] a);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a;
  endtask

  initial begin
    // Reset with port 0 reads toggling.
    csb0 = 1'b0; web0 = 1'b1; csb1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr0 = 8'(i); addr1 = 8'(i + 1);
      tick();
    end
    chk("rst_dout0", dout0_a, 32'h0);
    chk("rst_dout1", dout1_a, 32'h0);
    chk("rst_conf", {31'b0, conf_a}, 32'h0);
    chk("rst_oob", {31'b0, oob_a}, 32'h0);

    // Seed address 0, read it back, then reset again and check async clear.
    idle();
    resetn = 1'b1;
    tick();
    wr(8'h00, 32'hCAFEF00D, 4'hF); csb1 = 1'b1;
    tick();
    rd0(8'h00);
    tick();
    chk("pre_rst_rd", dout0_a, 32'hCAFEF00D);
    resetn = 1'b0;
    #1;
    chk("async_clr", dout0_a, 32'h0);
    for (int i = 0; i < 2; i++) begin
      addr0 = 8'(i); web0 = 1'b1;
      tick();
    end
    chk("rst_hold", dout0_a, 32'h0);
    resetn = 1'b1;
    rd0(8'h00);
    tick();
    chk("post_rst_rd", dout0_a, 32'hCAFEF00D);

    // Masked write.
    wr(8'h10, 32'hDEADBEEF, 4'hF); tick();
    wr(8'h10, 32'h00001100, 4'h2); tick();
    rd0(8'h10); tick();
    chk("mask_rd", dout0_a, 32'hDEAD11EF);

    // Fill, then stream port 0 up and port 1 down across the wrap.
    for (int k = 0; k < 256; k++) begin
      wr(8'(k), {4{8'(k)}}, 4'hF);
      tick();
    end
    csb0 = 1'b0; web0 = 1'b1; csb1 = 1'b0;
    for (int c = 0; c < 260; c++) begin
      addr0 = 8'(c); addr1 = 8'(255 - c);
      tick();
      chk("strm_p0", dout0_a, {4{8'(c)}});
      chk("strm_p1", dout1_a, {4{8'(255 - c)}});
    end
    chk("strm_conf", {31'b0, conf_a}, 32'h0);
    chk("strm_oob", {31'b0, oob_a}, 32'h0);

    // Same-address collision.
    idle();
    wr(8'h20, 32'h11111111, 4'hF); tick();
    wr(8'h20, 32'h22222222, 4'hF); csb1 = 1'b0; addr1 = 8'h20;
    tick();
`ifdef SRAM_RESPONDER_WRITE_THROUGH_EN
    chk("coll_dout1", dout1_a, 32'h22222222);
`else
    chk("coll_dout1", dout1_a, 32'h11111111);
`endif
    chk("coll_conf", {31'b0, conf_a}, 32'h1);
    csb0 = 1'b1; csb1 = 1'b0; addr1 = 8'h20;
    tick();
    chk("coll_conf_end", {31'b0, conf_a}, 32'h0);
    chk("coll_reread", dout1_a, 32'h22222222);

    // Out of range on the depth-200 instance.
    idle();
    wr(8'hC8, 32'hA5A5A5A5, 4'hF); tick();
    chk("oob_wr_flag", {31'b0, oob_b}, 32'h1);
    chk("oob_wr_noflag", {31'b0, oob_a}, 32'h0);
    rd0(8'hC8); tick();
    chk("oob_rd_dout", dout0_b, 32'h0);
    chk("oob_rd_flag", {31'b0, oob_b}, 32'h1);
    rd0(8'h48); tick();
    chk("oob_alias", dout0_b, 32'h48484848);
    chk("oob_clear", {31'b0, oob_b}, 32'h0);
    rd0(8'hC9); csb1 = 1'b0; addr1 = 8'hCA; tick();
    chk("oob_both_flag", {31'b0, oob_b}, 32'h1);
    chk("oob_both_dout1", dout1_b, 32'h0);
    idle(); tick();
    chk("oob_both_end", {31'b0, oob_b}, 32'h0);

    // Hold with both ports deselected and random inputs.
    rd0(8'h05); csb1 = 1'b0; addr1 = 8'h06; tick();
    chk("hold_pre0", dout0_a, 32'h05050505);
    chk("hold_pre1", dout1_a, 32'h06060606);
    idle();
    for (int i = 0; i < 5; i++) begin
      addr0 = 8'($urandom); addr1 = 8'($urandom);
      din0 = $urandom; wmask0 = 4'($urandom); web0 = 1'($urandom);
      tick();
      chk("hold_p0", dout0_a, 32'h05050505);
      chk("hold_p1", dout1_a, 32'h06060606);
    end

    // Zero-mask write is a no-op.
    wr(8'h07, 32'hFFFFFFFF, 4'h0); csb1 = 1'b1; tick();
    chk("noop_dout0", dout0_a, 32'h05050505);
    rd0(8'h07); tick();
    chk("noop_rd", dout0_a, 32'h07070707);
    idle(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_1rw1r_responder.md
Name: sram_1rw1r_responder

Overview:
- Synthesizable standard-cell responder for the OpenRAM macro port protocol: 1rw port 0 (csb0/web0/wmask0/addr0/din0 -> dout0) and read-only port 1 (csb1/addr1 -> dout1).
- Sits on the shared SRAM control/data bus in place of any macro slot without a working hard macro. It is the memory-side counterpart to the testchip control logic.
- Lets the control logic and capture registers be exercised end-to-end with known read/write semantics.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- WMASK_WIDTH, DATA_WIDTH/8, number of byte-lane write enables.
- ADDR_WIDTH, 8, address width of both ports.
- NUM_WORDS, 256, implemented depth; must satisfy NUM_WORDS <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock; both ports sample on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- csb0  input  1  port 0 chip select, active low.
- web0  input  1  port 0 write enable, active low; 1 = read.
- wmask0  input  WMASK_WIDTH  byte-lane write mask; bit i enables din0[8i+7:8i].
- addr0  input  ADDR_WIDTH  port 0 address.
- din0  input  DATA_WIDTH  port 0 write data.
- dout0  output  DATA_WIDTH  port 0 read data.
- csb1  input  1  port 1 chip select, active low.
- addr1  input  ADDR_WIDTH  port 1 address.
- dout1  output  DATA_WIDTH  port 1 read data.
- rw_conflict  output  1  one-cycle pulse: port 0 write and port 1 read hit the same address on the same edge.
- oob_access  output  1  one-cycle pulse: any enabled access with address >= NUM_WORDS.

Behaviour:
- Reset: dout0, dout1, rw_conflict and oob_access are forced to 0 asynchronously while resetn=0. Array contents are not reset and hold their values across reset.
- All inputs are sampled at posedge clk. There is no combinational path from inputs to outputs.
- Port 0 read (csb0=0, web0=1): dout0 <= mem[addr0] at edge N. Valid from N until the next port 0 read. Latency is 1 edge.
- Port 0 write (csb0=0, web0=0): at edge N, byte i of mem[addr0] <= din0 byte i for each wmask0[i]=1. Unmasked bytes are unchanged. dout0 holds its previous value.
  - wmask0=0 is a legal no-op write.
- Port 1 read (csb1=0): dout1 <= mem[addr1] at edge N, latency 1.
- Deselected port (csb=1): its dout holds. No array change.
- Same-address collision (port 0 write, port 1 read, addr0==addr1, same edge):
  - Without the optional feature, dout1 returns the pre-write word (read-before-write).
  - Array takes the merged write.
  - rw_conflict=1 for the cycle after edge N, then 0.
- Two reads to the same address: both return the same word. No flag.
- Out-of-range address (>= NUM_WORDS):
  - A write is discarded.
  - A read loads 0 into the corresponding dout.
  - oob_access=1 for one cycle.
  - Both ports out of range on the same edge give one pulse.
- Reset asserted mid-access: a write sampled on the same edge resetn rises is performed normally. No access occurs while resetn=0.
- Back-to-back accesses are accepted every cycle on both ports. There are no wait states and no handshake beyond csb.

Optional Feature:
- Macro: SRAM_RESPONDER_WRITE_THROUGH_EN.
- Defined: on a same-address collision, dout1 returns the post-write merged word (din0 bytes where wmask0=1, old bytes elsewhere). rw_conflict still pulses.
- Undefined: read-before-write, as specified above.

Decomposition:
- Shared defines file (the existing OpenRAM defines include) carries DATA_SIZE, ADDR_SIZE and WMASK_SIZE. The defaults above derive from them.
- One natural sub-module, sram_wmask_merge: combinational (old word, new word, mask) -> merged word.
  - Used for the array write.
  - Used for the write-through bypass when the macro is defined.
- The array, port registers and flags stay in the top module.

Test Plan:
- Reset check: resetn=0 with csb0=0, web0=1 toggling -> dout0=dout1=0, rw_conflict=oob_access=0. After release, the first read of address 0x00 returns the prior array content.
- Masked write: write 0xDEADBEEF to 0x10 with wmask0=0xF, then 0x00001100 with wmask0=0x2, then read 0x10 on port 0 -> dout0=0xDEAD11EF one edge after the read edge.
- Dual-port streaming:
  - Fill addr k with k*0x01010101 for k=0..255.
  - Read port 0 ascending and port 1 descending every cycle.
  - Each dout equals the expected word at latency 1, including wrap from 0xFF back to 0x00.
- Collision: mem[0x20]=0x11111111; port 0 writes 0x22222222 mask 0xF and port 1 reads 0x20 on the same edge.
  - Macro undefined -> dout1=0x11111111.
  - Macro defined -> dout1=0x22222222.
  - rw_conflict=1 for exactly one cycle in both cases.
  - A following port 1 read gives 0x22222222.
- Out-of-range: with NUM_WORDS=200, write 0xA5A5A5A5 to 0xC8, then read 0xC8 -> dout0=0; oob_access pulses on both edges. mem[0x48] is unchanged (no aliasing).
- Hold and no-op:
  - csb0=csb1=1 for 5 cycles with random addr/din -> both douts unchanged.
  - Write with wmask0=0 -> a subsequent read returns the old word.
